custom_ip_reg_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the custom IP's register-file interface between N_REQ bus requesters (for example, the core and a DMA port).
- Accepts single-beat read/write requests.
- Drives the IP's per-register write-enable and data lines.
- Waits for the IP's per-register data-ready flag on reads.
- Returns a one-cycle response to the winning requester.
- Sits between the SoC peripheral interconnect and the custom IP.

---
 rtl/custom_ip_reg_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_custom_ip_reg_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_ip_reg_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter/sequencer sharing the custom IP register file between N_REQ requesters.
// Optional read-wait timeout is enabled by defining CUSTOM_IP_ARB_TIMEOUT_EN.
module custom_ip_reg_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned NUM_REGS    = 3,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           we_i,
    input  logic [N_REQ*ADDR_W-1:0]    addr_i,
    input  logic [N_REQ*DATA_W-1:0]    wdata_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [N_REQ-1:0]           rvalid_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic [NUM_REGS-1:0]        ip_wen_o,
    output logic [DATA_W-1:0]          ip_wdata_o,
    input  logic [NUM_REGS*DATA_W-1:0] ip_rdata_i,
    input  logic [NUM_REGS-1:0]        ip_rvalid_i
);

    localparam int unsigned IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned REQ_SLOTS = 1 << IDX_W;
    localparam int unsigned REG_SLOTS = 1 << ADDR_W;

    localparam logic [IDX_W:0]   NREQ_L   = (IDX_W + 1)'(N_REQ);
    localparam logic [ADDR_W:0]  NREGS_L  = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

`ifdef CUSTOM_IP_ARB_TIMEOUT_EN
    localparam int unsigned      CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_win;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [NUM_REGS-1:0] r_ip_wen;
    logic [DATA_W-1:0]   r_ip_wdata;
`ifdef CUSTOM_IP_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]    r_cnt;
`endif

    // Inputs padded to power-of-two slot counts so every index width matches exactly.
    logic [REQ_SLOTS-1:0] w_req_ext;
    logic [REQ_SLOTS-1:0] w_we_ext;
    logic [ADDR_W-1:0]    w_addr_arr  [REQ_SLOTS];
    logic [DATA_W-1:0]    w_wdata_arr [REQ_SLOTS];
    logic [REG_SLOTS-1:0] w_flag_ext;
    logic [DATA_W-1:0]    w_rdata_arr [REG_SLOTS];

    assign w_req_ext  = REQ_SLOTS'(req_i);
    assign w_we_ext   = REQ_SLOTS'(we_i);
    assign w_flag_ext = REG_SLOTS'(ip_rvalid_i);

    for (genvar k = 0; k < REQ_SLOTS; k++) begin : g_req_slot
        if (k < N_REQ) begin : g_used
            assign w_addr_arr[k]  = addr_i[k*ADDR_W +: ADDR_W];
            assign w_wdata_arr[k] = wdata_i[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_addr_arr[k]  = '0;
            assign w_wdata_arr[k] = '0;
        end
    end

    for (genvar k = 0; k < REG_SLOTS; k++) begin : g_reg_slot
        if (k < NUM_REGS) begin : g_used
            assign w_rdata_arr[k] = ip_rdata_i[k*DATA_W +: DATA_W];
        end else begin : g_pad
            assign w_rdata_arr[k] = '0;
        end
    end

    logic [IDX_W-1:0]    w_next_ptr;
    logic [IDX_W-1:0]    w_base;
    logic [IDX_W-1:0]    w_win;
    logic                w_any;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic                w_sel_we;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_ok;
    logic                w_addr_ok;
    logic                w_flag;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic [N_REQ-1:0]    w_win_oh;
    logic [N_REQ-1:0]    w_cur_oh;
    logic [NUM_REGS-1:0] w_wen_dec;

    assign w_next_ptr = (r_win == LAST_IDX) ? '0 : r_win + IDX_W'(1);
    // Leaving RESP arbitrates immediately, already using the advanced pointer.
    assign w_base     = (r_state == StResp) ? w_next_ptr : r_ptr;

    always_comb begin
        logic [IDX_W:0] w_sum;
        w_sum = '0;
        w_win = w_base;
        w_any = 1'b0;
        // Walk downward so the closest set bit at/after w_base is the last one kept.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_sum = {1'b0, w_base} + (IDX_W + 1)'(i);
            if (w_sum >= NREQ_L) begin
                w_sum = w_sum - NREQ_L;
            end
            if (w_req_ext[w_sum[IDX_W-1:0]]) begin
                w_win = w_sum[IDX_W-1:0];
                w_any = 1'b1;
            end
        end
    end

    assign w_sel_addr  = w_addr_arr[w_win];
    assign w_sel_we    = w_we_ext[w_win];
    assign w_sel_wdata = w_wdata_arr[w_win];
    assign w_sel_ok    = ({1'b0, w_sel_addr} < NREGS_L);
    assign w_addr_ok   = ({1'b0, r_addr} < NREGS_L);
    assign w_flag      = w_flag_ext[r_addr];
    assign w_rdata_sel = w_rdata_arr[r_addr];

    always_comb begin
        w_win_oh  = '0;
        w_cur_oh  = '0;
        w_wen_dec = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_win_oh[k] = (w_win == IDX_W'(k));
            w_cur_oh[k] = (r_win == IDX_W'(k));
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            w_wen_dec[k] = (w_sel_addr == ADDR_W'(k));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_win      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_ip_wen   <= '0;
            r_ip_wdata <= '0;
`ifdef CUSTOM_IP_ARB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_gnt      <= '0;
            r_rvalid   <= '0;
            r_ip_wen   <= '0;
            r_ip_wdata <= '0;
            unique case (r_state)
                StIdle, StResp: begin
                    if (r_state == StResp) begin
                        r_ptr <= w_next_ptr;
                    end
                    if (w_any) begin
                        r_win   <= w_win;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_gnt   <= w_win_oh;
                        r_state <= StIssue;
                        if (w_sel_we && w_sel_ok) begin
                            r_ip_wen   <= w_wen_dec;
                            r_ip_wdata <= w_sel_wdata;
                        end
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StIssue: begin
                    if (!w_addr_ok) begin
                        r_rvalid <= w_cur_oh;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_state  <= StResp;
                    end else if (r_we) begin
                        r_rvalid <= w_cur_oh;
                        r_err    <= 1'b0;
                        r_rdata  <= '0;
                        r_state  <= StResp;
                    end else begin
                        r_state  <= StWait;
`ifdef CUSTOM_IP_ARB_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end
                end
                StWait: begin
                    if (w_flag) begin
                        r_rvalid <= w_cur_oh;
                        r_err    <= 1'b0;
                        r_rdata  <= w_rdata_sel;
                        r_state  <= StResp;
`ifdef CUSTOM_IP_ARB_TIMEOUT_EN
                    end else if (r_cnt == CNT_LAST) begin
                        r_rvalid <= w_cur_oh;
                        r_err    <= 1'b1;
                        r_rdata  <= '0;
                        r_state  <= StResp;
                    end else begin
                        r_cnt    <= r_cnt + CNT_W'(1);
`endif
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign gnt_o      = r_gnt;
    assign rvalid_o   = r_rvalid;
    assign rdata_o    = r_rdata;
    assign err_o      = r_err;
    assign busy_o     = (r_state != StIdle);
    assign ip_wen_o   = r_ip_wen;
    assign ip_wdata_o = r_ip_wdata;

endmodule

// File: tb/tb_custom_ip_reg_arbiter.sv
`timescale 1ns/1ps
// Bench for custom_ip_reg_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_custom_ip_reg_arbiter;

    localparam int N_REQ       = 2;
    localparam int NUM_REGS    = 3;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 2;
    localparam int TIMEOUT_CYC = 16;

    logic                       clk_i;
    logic                       rst_ni;
    logic [N_REQ-1:0]           req_i;
    logic [N_REQ-1:0]           we_i;
    logic [N_REQ*ADDR_W-1:0]    addr_i;
    logic [N_REQ*DATA_W-1:0]    wdata_i;
    logic [N_REQ-1:0]           gnt_o;
    logic [N_REQ-1:0]           rvalid_o;
    logic [DATA_W-1:0]          rdata_o;
    logic                       err_o;
    logic                       busy_o;
    logic [NUM_REGS-1:0]        ip_wen_o;
    logic [DATA_W-1:0]          ip_wdata_o;
    logic [NUM_REGS*DATA_W-1:0] ip_rdata_i;
    logic [NUM_REGS-1:0]        ip_rvalid_i;

    int checks   = 0;
    int failures = 0;

    custom_ip_reg_arbiter #(
        .N_REQ      (N_REQ),
        .NUM_REGS   (NUM_REGS),
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .ip_wen_o   (ip_wen_o),
        .ip_wdata_o (ip_wdata_o),
        .ip_rdata_i (ip_rdata_i),
        .ip_rvalid_i(ip_rvalid_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int k, input bit we, input int addr, input logic [31:0] data);
        req_i[k]                      = 1'b1;
        we_i[k]                       = we;
        addr_i[k*ADDR_W +: ADDR_W]    = ADDR_W'(addr);
        wdata_i[k*DATA_W +: DATA_W]   = data;
    endtask

    // Transaction-level model: one outstanding transaction, progressing one step per edge.
    // m_stage: 0 none, 1 granted, 2 waiting for ready flag, 3 responding.
    int                  m_stage, m_ptr, m_who, m_addr, m_waited, m_k;
    bit                  m_we, m_found;
    logic [DATA_W-1:0]   m_data;
    logic [N_REQ-1:0]    e_gnt, e_rvalid;
    logic [DATA_W-1:0]   e_rdata, e_wdata;
    logic                e_err;
    logic [NUM_REGS-1:0] e_wen;

    initial begin
        m_stage = 0; m_ptr = 0; m_who = 0; m_addr = 0; m_waited = 0; m_we = 0; m_data = '0;
        e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_err = 1'b0; e_wen = '0; e_wdata = '0;
        forever begin
            @(posedge clk_i);
            if (!rst_ni) begin
                m_stage = 0; m_ptr = 0;
                e_gnt = '0; e_rvalid = '0; e_rdata = '0; e_err = 1'b0; e_wen = '0; e_wdata = '0;
            end else begin
                e_gnt = '0; e_rvalid = '0; e_wen = '0;
                if (m_stage == 3) m_ptr = (m_who + 1) % N_REQ;
                if (m_stage == 0 || m_stage == 3) begin
                    m_stage = 0;
                    m_found = 0;
                    for (int i = 0; i < N_REQ; i++) begin
                        m_k = (m_ptr + i) % N_REQ;
                        if (!m_found && req_i[m_k]) begin
                            m_found = 1;
                            m_who   = m_k;
                        end
                    end
                    if (m_found) begin
                        m_stage       = 1;
                        m_we          = we_i[m_who];
                        m_addr        = int'(addr_i[m_who*ADDR_W +: ADDR_W]);
                        m_data        = wdata_i[m_who*DATA_W +: DATA_W];
                        e_gnt[m_who]  = 1'b1;
                        if (m_we && m_addr < NUM_REGS) begin
                            e_wen[m_addr] = 1'b1;
                            e_wdata       = m_data;
                        end
                    end
                end else if (m_stage == 1) begin
                    if (m_addr >= NUM_REGS) begin
                        e_rvalid[m_who] = 1'b1; e_err = 1'b1; e_rdata = '0; m_stage = 3;
                    end else if (m_we) begin
                        e_rvalid[m_who] = 1'b1; e_err = 1'b0; e_rdata = '0; m_stage = 3;
                    end else begin
                        m_stage = 2; m_waited = 0;
                    end
                end else begin
                    if (ip_rvalid_i[m_addr]) begin
                        e_rvalid[m_who] = 1'b1; e_err = 1'b0;
                        e_rdata = ip_rdata_i[m_addr*DATA_W +: DATA_W];
                        m_stage = 3;
                    end else begin
                        m_waited++;
`ifdef CUSTOM_IP_ARB_TIMEOUT_EN
                        if (m_waited == TIMEOUT_CYC) begin
                            e_rvalid[m_who] = 1'b1; e_err = 1'b1; e_rdata = '0; m_stage = 3;
                        end
`endif
                    end
                end
            end
            #1;
            check("m_gnt", gnt_o, e_gnt);
            check("m_rvalid", rvalid_o, e_rvalid);
            check("m_rdata", rdata_o, e_rdata);
            check("m_err", err_o, e_err);
            check("m_busy", busy_o, m_stage != 0);
            check("m_wen", ip_wen_o, e_wen);
            if (e_wen != 0) check("m_wdata", ip_wdata_o, e_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    logic [N_REQ-1:0] t3_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [N_REQ-1:0] t3_gnt [4];
    logic [N_REQ-1:0] t3_rv  [4];
    int               t3_ng, t3_nr;

    initial begin
        rst_ni = 1'b0; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
        ip_rdata_i = '0; ip_rvalid_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_gnt", gnt_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_wen", ip_wen_o, 0);
        check("rst_wdata", ip_wdata_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_err", err_o, 0);
        rst_ni      = 1'b1;
        ip_rvalid_i = 3'b111;
        ip_rdata_i  = {32'h1234_5678, 32'h2222_2222, 32'h1111_1111};
        @(negedge clk_i);

        // Single write
        set_req(0, 1'b1, 1, 32'hA5A5_0001);
        @(posedge clk_i); #1;
        check("t1_gnt", gnt_o, 2'b01);
        check("t1_wen", ip_wen_o, 3'b010);
        check("t1_wdata", ip_wdata_o, 32'hA5A5_0001);
        @(negedge clk_i); req_i[0] = 1'b0;
        @(posedge clk_i); #1;
        check("t1_rvalid", rvalid_o, 2'b01);
        check("t1_err", err_o, 0);
        check("t1_wen_once", ip_wen_o, 0);
        repeat (2) @(negedge clk_i);

        // Read with ready flag already high
        set_req(1, 1'b0, 2, 32'h0);
        @(posedge clk_i); #1;
        check("t2_gnt", gnt_o, 2'b10);
        @(negedge clk_i); req_i[1] = 1'b0;
        @(posedge clk_i); #1;
        check("t2_no_rvalid_c2", rvalid_o, 0);
        @(posedge clk_i); #1;
        check("t2_rvalid", rvalid_o, 2'b10);
        check("t2_rdata", rdata_o, 32'h1234_5678);
        check("t2_err", err_o, 0);
        repeat (2) @(negedge clk_i);

        // Contention
        set_req(0, 1'b1, 0, 32'h0000_C000);
        set_req(1, 1'b1, 1, 32'h0000_C001);
        t3_ng = 0; t3_nr = 0;
        for (int c = 0; c < 30 && t3_nr < 4; c++) begin
            @(posedge clk_i); #1;
            if (gnt_o != 0 && t3_ng < 4) begin t3_gnt[t3_ng] = gnt_o; t3_ng++; end
            if (rvalid_o != 0 && t3_nr < 4) begin t3_rv[t3_nr] = rvalid_o; t3_nr++; end
            if (t3_ng == 4) req_i = '0;
        end
        req_i = '0;
        check("t3_ngrants", t3_ng, 4);
        check("t3_nresps", t3_nr, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < t3_ng) check("t3_grant_order", t3_gnt[i], t3_exp[i]);
            if (i < t3_nr) check("t3_resp_order", t3_rv[i], t3_exp[i]);
        end
        repeat (2) @(negedge clk_i);

        // Bad address
        set_req(0, 1'b1, 3, 32'hDEAD_BEEF);
        @(posedge clk_i); #1;
        check("t4_gnt", gnt_o, 2'b01);
        check("t4_wen", ip_wen_o, 0);
        @(negedge clk_i); req_i[0] = 1'b0;
        @(posedge clk_i); #1;
        check("t4_rvalid", rvalid_o, 2'b01);
        check("t4_err", err_o, 1);
        check("t4_rdata", rdata_o, 0);
        repeat (2) @(negedge clk_i);

        // Delayed ready flag
        ip_rvalid_i = 3'b000;
        ip_rdata_i[31:0] = 32'hCAFE_0000;
        set_req(0, 1'b0, 0, 32'h0);
        @(posedge clk_i); #1;
        check("t5_gnt", gnt_o, 2'b01);
        @(negedge clk_i); req_i[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            check("t5_busy", busy_o, 1);
            check("t5_no_rvalid", rvalid_o, 0);
        end
        @(negedge clk_i); ip_rvalid_i = 3'b001;
        @(posedge clk_i); #1;
        check("t5_rvalid", rvalid_o, 2'b01);
        check("t5_rdata", rdata_o, 32'hCAFE_0000);
        check("t5_err", err_o, 0);
        @(negedge clk_i); ip_rvalid_i = 3'b000;
        repeat (2) @(negedge clk_i);

        // Reset mid-WAIT; pointer is 1 here, reset must bring it back to 0
        set_req(0, 1'b0, 0, 32'h0);
        @(posedge clk_i); #1;
        check("t6_gnt", gnt_o, 2'b01);
        @(negedge clk_i); req_i[0] = 1'b0;
        @(posedge clk_i); #1;
        check("t6_busy_wait", busy_o, 1);
        @(negedge clk_i); rst_ni = 1'b0;
        #1;
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_gnt", gnt_o, 0);
        check("t6_rst_rvalid", rvalid_o, 0);
        check("t6_rst_rdata", rdata_o, 0);
        check("t6_rst_err", err_o, 0);
        check("t6_rst_wen", ip_wen_o, 0);
        check("t6_rst_wdata", ip_wdata_o, 0);
        ip_rvalid_i = 3'b111;
        @(posedge clk_i); #1;
        check("t6_no_rvalid", rvalid_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_req(0, 1'b0, 1, 32'h0);
        set_req(1, 1'b0, 1, 32'h0);
        @(posedge clk_i); #1;
        check("t6_first_gnt", gnt_o, 2'b01);

        // Randomized traffic; requesters hold until granted
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_i);
            for (int k = 0; k < N_REQ; k++) begin
                if (req_i[k] && gnt_o[k]) req_i[k] = 1'b0;
                if (!req_i[k] && $urandom_range(0, 2) == 0)
                    set_req(k, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
            end
            for (int r = 0; r < NUM_REGS; r++) begin
                ip_rvalid_i[r] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 3) == 0) ip_rdata_i[r*DATA_W +: DATA_W] = $urandom;
            end
            rst_ni = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        req_i  = '0;
        repeat (10) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
